// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one combinational ALU: registers the operands of the
// granted request, captures Result/Zero one cycle later and returns them on that port.
module alu_share_arb #(
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  output logic              resp0_err,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
  output logic              resp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_next;
  logic              last_grant, gnt, err_pending;
  logic              sel, hs, resp_hs, op_legal;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [2:0]        sel_op;

  // Both valid: fixed priority favours port 0, round-robin favours the port not served last.
  always_comb begin
    sel        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_next = state;
    if (req0_valid && req1_valid) begin
      sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else begin
      sel = req1_valid;
    end
    if (state == IDLE && !rst) begin
      req0_ready = req0_valid && !sel;
      req1_ready = req1_valid && sel;
    end
    hs      = req0_ready || req1_ready;
    resp_hs = (state == RESP) && (gnt ? resp1_ready : resp0_ready);
    sel_a   = sel ? req1_a  : req0_a;
    sel_b   = sel ? req1_b  : req0_b;
    sel_op  = sel ? req1_op : req0_op;
    op_legal = (sel_op == 3'b000) || (sel_op == 3'b001) || (sel_op == 3'b010) ||
               (sel_op == 3'b011) || (sel_op == 3'b101);
    case (state)
      IDLE:    if (hs) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      gnt          <= 1'b0;
      err_pending  <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= 3'b000;
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp0_zero   <= 1'b0;
      resp0_err    <= 1'b0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      resp1_zero   <= 1'b0;
      resp1_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            // Illegal opcodes still occupy the ALU slot, but with a harmless add.
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_ctrl    <= op_legal ? sel_op : 3'b000;
            err_pending <= !op_legal;
            gnt         <= sel;
          end
        end
        EXEC: begin
          if (!gnt) begin
            resp0_valid  <= 1'b1;
            resp0_result <= err_pending ? '0 : alu_result;
            resp0_zero   <= err_pending ? 1'b0 : alu_zero;
            resp0_err    <= err_pending;
          end else begin
            resp1_valid  <= 1'b1;
            resp1_result <= err_pending ? '0 : alu_result;
            resp1_zero   <= err_pending ? 1'b0 : alu_zero;
            resp1_err    <= err_pending;
          end
          err_pending <= 1'b0;
        end
        RESP: begin
          if (resp_hs) begin
            resp0_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_err   <= 1'b0;
            last_grant  <= gnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomised scoreboard bench for alu_share_arb: a stimulus process predicts grants and
// responses from the arbitration rules, a monitor process checks every presented response.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp0_zero, resp0_err;
  logic        resp1_valid, resp1_ready, resp1_zero, resp1_err;
  logic [31:0] resp0_result, resp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;

  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic        f_resp0_valid, f_resp0_zero, f_resp0_err;
  logic        f_resp1_valid, f_resp1_zero, f_resp1_err;
  logic [31:0] f_resp0_result, f_resp1_result;
  logic [31:0] f_alu_a, f_alu_b, f_alu_result;
  logic [2:0]  f_alu_ctrl;
  logic        f_alu_zero;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        err;
    int          hs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb #(.DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_zero(resp0_zero), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_zero(resp1_zero), .resp1_err(resp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_share_arb #(.DATA_W(32), .FIXED_PRIO(1)) dut_fix (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(32'd1), .req0_b(32'd2), .req0_op(3'b000),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(32'd4), .req1_b(32'd4), .req1_op(3'b001),
    .resp0_valid(f_resp0_valid), .resp0_ready(1'b1), .resp0_result(f_resp0_result),
    .resp0_zero(f_resp0_zero), .resp0_err(f_resp0_err),
    .resp1_valid(f_resp1_valid), .resp1_ready(1'b1), .resp1_result(f_resp1_result),
    .resp1_zero(f_resp1_zero), .resp1_err(f_resp1_err),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_ctrl(f_alu_ctrl), .alu_result(f_alu_result), .alu_zero(f_alu_zero)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU standing in for the real one on both instances.
  always_comb begin
    alu_result   = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_zero     = (alu_result == 32'd0);
    f_alu_result = alu_fn(f_alu_a, f_alu_b, f_alu_ctrl);
    f_alu_zero   = (f_alu_result == 32'd0);
  end

  function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int hs);
    exp_t e;
    bit legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b011) || (op == 3'b101);
    e.result = legal ? alu_fn(a, b, op) : 32'd0;
    e.zero   = legal ? (e.result == 32'd0) : 1'b0;
    e.err    = !legal;
    e.hs     = hs;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd5;
      1:       return 32'd7;
      2:       return 32'd3;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'hF0;
      5:       return 32'h3C;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " req0_ready"}, {31'd0, req0_ready}, 32'd0);
    checkOutput({tag, " req1_ready"}, {31'd0, req1_ready}, 32'd0);
    checkOutput({tag, " resp0_valid"}, {31'd0, resp0_valid}, 32'd0);
    checkOutput({tag, " resp1_valid"}, {31'd0, resp1_valid}, 32'd0);
    checkOutput({tag, " resp0_err"}, {31'd0, resp0_err}, 32'd0);
    checkOutput({tag, " resp1_err"}, {31'd0, resp1_err}, 32'd0);
    checkOutput({tag, " resp0_result"}, resp0_result, 32'd0);
    checkOutput({tag, " resp1_result"}, resp1_result, 32'd0);
    checkOutput({tag, " resp0_zero"}, {31'd0, resp0_zero}, 32'd0);
    checkOutput({tag, " resp1_zero"}, {31'd0, resp1_zero}, 32'd0);
    checkOutput({tag, " alu_a"}, alu_a, 32'd0);
    checkOutput({tag, " alu_b"}, alu_b, 32'd0);
    checkOutput({tag, " alu_ctrl"}, {29'd0, alu_ctrl}, 32'd0);
  endtask

  // Arbitration model state: one operation in flight at a time.
  bit   busy = 0;
  bit   bgnt = 0;
  int   bstart = 0;
  bit   last = 1;

  task automatic applyStimulus(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                               input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                               input bit rr0, input bit rr1, output bit took0, output bit took1);
    bit e0, e1;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    resp0_ready = rr0; resp1_ready = rr1;
    #2;
    e0 = !busy && !rst && v0 && (!v1 || last);
    e1 = !busy && !rst && v1 && (!v0 || !last);
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    took0 = e0;
    took1 = e1;
    if (e0 || e1) begin
      busy = 1; bgnt = e1; bstart = cyc;
      if (e0) q0.push_back(expect_of(a0, b0, op0, cyc));
      else    q1.push_back(expect_of(a1, b1, op1, cyc));
    end else if (busy && cyc >= bstart + 2 && (bgnt ? rr1 : rr0)) begin
      busy = 0;
      last = bgnt;
    end
  endtask

  // Monitor: every cycle a response is presented it must match the oldest expectation.
  initial begin
    bit pv0 = 0, pv1 = 0;
    forever begin
      @(negedge clk);
      #2;
      if (resp0_valid && resp1_valid) checkOutput("both resp valid", 32'd1, 32'd0);
      if (resp0_valid) begin
        if (q0.size() == 0) checkOutput("resp0 unexpected valid", 32'd1, 32'd0);
        else begin
          if (!pv0) checkOutput("resp0 latency", cyc, q0[0].hs + 2);
          checkOutput("resp0_result", resp0_result, q0[0].result);
          checkOutput("resp0_zero", {31'd0, resp0_zero}, {31'd0, q0[0].zero});
          checkOutput("resp0_err", {31'd0, resp0_err}, {31'd0, q0[0].err});
          if (resp0_ready) void'(q0.pop_front());
        end
      end
      if (resp1_valid) begin
        if (q1.size() == 0) checkOutput("resp1 unexpected valid", 32'd1, 32'd0);
        else begin
          if (!pv1) checkOutput("resp1 latency", cyc, q1[0].hs + 2);
          checkOutput("resp1_result", resp1_result, q1[0].result);
          checkOutput("resp1_zero", {31'd0, resp1_zero}, {31'd0, q1[0].zero});
          checkOutput("resp1_err", {31'd0, resp1_err}, {31'd0, q1[0].err});
          if (resp1_ready) void'(q1.pop_front());
        end
      end
      pv0 = resp0_valid && !resp0_ready;
      pv1 = resp1_valid && !resp1_ready;
    end
  end

  initial begin
    bit p0 = 0, p1 = 0, t0, t1, rst_done = 0;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [2:0]  op0 = 0, op1 = 0;
    int grants[$];

    rst = 1;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    f_req0_valid = 0; f_req1_valid = 0;
    repeat (3) @(negedge clk);
    #2;
    checkResetValues("reset");
    @(negedge clk);
    rst = 0;

    // Fixed-priority instance: port 0 must win every contested round.
    f_req0_valid = 1; f_req1_valid = 1;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      @(negedge clk);
      #2;
      if (f_req0_ready) grants.push_back(0);
      if (f_req1_ready) grants.push_back(1);
    end
    checkOutput("fixed grant count", grants.size(), 32'd4);
    foreach (grants[i]) checkOutput("fixed grant port", grants[i], 32'd0);
    f_req0_valid = 0; f_req1_valid = 0;

    // Directed opener covering the worked examples, then randomised traffic.
    applyStimulus(1, 32'd5, 32'd7, 3'b000, 0, 0, 0, 0, 1, 1, t0, t1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, t0, t1);
    applyStimulus(0, 0, 0, 0, 1, 32'd3, 32'd3, 3'b001, 1, 1, t0, t1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, t0, t1);
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 3'b101, 1, 1, t0, t1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, t0, t1);
    applyStimulus(1, 32'd9, 32'd9, 3'b110, 0, 0, 0, 0, 1, 1, t0, t1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, t0, t1);
    applyStimulus(1, 32'hF0, 32'h3C, 3'b010, 0, 0, 0, 0, 0, 0, t0, t1);
    repeat (6) applyStimulus(0, 0, 0, 0, 1, 32'd1, 32'd1, 3'b000, 0, 0, t0, t1);
    p1 = !t1; a1 = 32'd1; b1 = 32'd1; op1 = 3'b000;
    if (t1) p1 = 0;

    for (int it = 0; it < 1500; it++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1; a0 = pick(); b0 = pick(); op0 = 3'($urandom_range(0, 7)); end
      if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1; a1 = pick(); b1 = pick(); op1 = 3'($urandom_range(0, 7)); end
      if (p0 && $urandom_range(0, 29) == 0) p0 = 0;
      applyStimulus(p0, a0, b0, op0, p1, a1, b1, op1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t0, t1);
      if (t0) p0 = 0;
      if (t1) p1 = 0;
      if (!rst_done && it > 300 && busy && cyc == bstart + 1) begin
        rst = 1;
        rst_done = 1;
        if (bgnt) void'(q1.pop_back());
        else      void'(q0.pop_back());
        busy = 0;
        last = 1;
        p0 = 0; p1 = 0;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #2;
        checkResetValues("reset in EXEC");
        rst = 0;
      end
    end
    checkOutput("reset in EXEC exercised", {31'd0, rst_done}, 32'd1);

    repeat (10) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, t0, t1);
    checkOutput("resp0 queue drained", q0.size(), 32'd0);
    checkOutput("resp1 queue drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
